// File: rtl/cnt_cmd_gen_pkg.sv
// Shared types and defaults for the counting-game command stage.
package cnt_game_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEB_W_DEF        = 16;
    localparam int DEB_CYCLES_DEF   = 50000;
    localparam int ROUND_W_DEF      = 28;
    localparam int ROUND_CYCLES_DEF = 100_000_000;
endpackage

// File: rtl/cnt_cmd_gen_if.sv
// Button/switch inputs, counter pins and round status of the command stage.
interface cnt_cmd_gen_if;
    logic start_n;
    logic press_n;
    logic dir_sw;
    logic tc;
    logic ld;
    logic cnt;
    logic up;
    logic win;
    logic timeout;
    logic busy;

    modport master (
        input  start_n, press_n, dir_sw, tc,
        output ld, cnt, up, win, timeout, busy
    );
    modport slave (
        output start_n, press_n, dir_sw, tc,
        input  ld, cnt, up, win, timeout, busy
    );
endinterface

// File: rtl/cnt_cmd_gen_debounce.sv
// Raw active-low button -> synchronised, debounced level -> one-cycle press pulse.
module btn_debounce #(
    parameter int DEB_W      = 16,
    parameter int DEB_CYCLES = 50000
) (
    input  logic inter_clk,
    input  logic clr,
    input  logic btn_n,
    output logic fall
);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1, sync2, stable, stable_q;
    logic [DEB_W-1:0] dcnt;

    always_ff @(posedge inter_clk or negedge clr) begin
        if (!clr) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_q <= 1'b1;
            dcnt     <= '0;
        end else begin
            sync1    <= btn_n;
            sync2    <= sync1;
            stable_q <= stable;
            // Any return to the accepted level restarts the qualification window.
            if (sync2 == stable) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                stable <= sync2;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    assign fall = stable_q & ~stable;
endmodule

// File: rtl/cnt_cmd_gen.sv
// Command stage for ud_counter_block: button conditioning, round FSM, timer.
module cnt_cmd_gen
    import cnt_game_pkg::*;
#(
    parameter int DEB_W        = DEB_W_DEF,
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int ROUND_W      = ROUND_W_DEF,
    parameter int ROUND_CYCLES = ROUND_CYCLES_DEF
) (
    input logic           inter_clk,
    input logic           clr,
    cnt_cmd_gen_if.master bus
);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUND_CYCLES - 1);

    state_t             state;
    logic [ROUND_W-1:0] timer;
    logic               start_ev, press_ev;

    btn_debounce #(.DEB_W(DEB_W), .DEB_CYCLES(DEB_CYCLES)) u_start (
        .inter_clk (inter_clk),
        .clr       (clr),
        .btn_n     (bus.start_n),
        .fall      (start_ev)
    );

    btn_debounce #(.DEB_W(DEB_W), .DEB_CYCLES(DEB_CYCLES)) u_press (
        .inter_clk (inter_clk),
        .clr       (clr),
        .btn_n     (bus.press_n),
        .fall      (press_ev)
    );

    always_ff @(posedge inter_clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            timer       <= '0;
            bus.ld      <= 1'b0;
            bus.cnt     <= 1'b0;
            bus.up      <= 1'b1;
            bus.win     <= 1'b0;
            bus.timeout <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            bus.ld  <= 1'b0;
            bus.cnt <= 1'b0;
            // Start wins everywhere except LOAD, including aborting a live round.
            if (start_ev && state != LOAD) begin
                state       <= LOAD;
                bus.ld      <= 1'b1;
                bus.up      <= bus.dir_sw;
                bus.win     <= 1'b0;
                bus.timeout <= 1'b0;
                bus.busy    <= 1'b1;
            end else begin
                case (state)
                    LOAD: begin
                        state <= RUN;
                        timer <= '0;
                    end
                    RUN: begin
                        timer <= timer + 1'b1;
                        // Presses coinciding with round end are dropped so the counter never passes terminal.
                        if (bus.tc) begin
                            state    <= DONE;
                            bus.win  <= 1'b1;
                            bus.busy <= 1'b0;
                        end else if (timer == ROUND_LAST) begin
                            state       <= DONE;
                            bus.timeout <= 1'b1;
                            bus.busy    <= 1'b0;
                        end else if (press_ev) begin
                            bus.cnt <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cnt_cmd_gen.sv
// Directed bench: phase table plus hand sequences for latency and collision corners.
module tb_cnt_cmd_gen;
    import cnt_game_pkg::*;

    logic inter_clk, clr;
    logic start_n, press_n, dir_sw;
    logic tc_ovr_en, tc_ovr;
    logic [3:0] q_a, q_w;
    int n_chk, n_fail;
    int ld_n, cnt_n, cnt_n_w;

    cnt_cmd_gen_if bus_a();
    cnt_cmd_gen_if bus_w();

    // Main instance uses the short round; the long-round twin lets 14 presses fit for the win case.
    cnt_cmd_gen #(.DEB_W(8), .DEB_CYCLES(4), .ROUND_W(8), .ROUND_CYCLES(64)) dut_a (
        .inter_clk (inter_clk), .clr (clr), .bus (bus_a)
    );
    cnt_cmd_gen #(.DEB_W(8), .DEB_CYCLES(4), .ROUND_W(12), .ROUND_CYCLES(1024)) dut_w (
        .inter_clk (inter_clk), .clr (clr), .bus (bus_w)
    );

    assign bus_a.start_n = start_n;
    assign bus_a.press_n = press_n;
    assign bus_a.dir_sw  = dir_sw;
    assign bus_w.start_n = start_n;
    assign bus_w.press_n = press_n;
    assign bus_w.dir_sw  = dir_sw;

    // Downstream counter models, loading num=1, 4-bit.
    always_ff @(posedge inter_clk or negedge clr) begin
        if (!clr)            q_a <= 4'd0;
        else if (bus_a.ld)   q_a <= 4'd1;
        else if (bus_a.cnt)  q_a <= bus_a.up ? q_a + 4'd1 : q_a - 4'd1;
    end
    always_ff @(posedge inter_clk or negedge clr) begin
        if (!clr)            q_w <= 4'd0;
        else if (bus_w.ld)   q_w <= 4'd1;
        else if (bus_w.cnt)  q_w <= bus_w.up ? q_w + 4'd1 : q_w - 4'd1;
    end
    assign bus_a.tc = tc_ovr_en ? tc_ovr : (bus_a.up ? (q_a == 4'd15) : (q_a == 4'd0));
    assign bus_w.tc = bus_w.up ? (q_w == 4'd15) : (q_w == 4'd0);

    initial inter_clk = 1'b0;
    always #5 inter_clk = ~inter_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge inter_clk);
        #1;
        if (bus_a.ld)  ld_n++;
        if (bus_a.cnt) cnt_n++;
        if (bus_w.cnt) cnt_n_w++;
        chk("ld_cnt_exclusive", 32'({bus_a.ld & bus_a.cnt, bus_w.ld & bus_w.cnt}), 32'd0);
    endtask

    task automatic wait_ld(input bit on_w, input string name);
        int k = 0;
        while (!(on_w ? bus_w.ld : bus_a.ld) && k < 20) begin
            step();
            k++;
        end
        chk(name, 32'(on_w ? bus_w.ld : bus_a.ld), 32'd1);
    endtask

    typedef struct {
        logic start_n, press_n, dir_sw;
        int   ncyc;
        int   ld_n, cnt_n;
        logic up, win, timeout, busy;
    } vec_t;
    vec_t tbl [12];

    initial begin
        //            st    pr    dir  cyc ld cnt up    win   to    busy
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 10, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0}; // press in IDLE discarded
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 10, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1}; // start, down round
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 10, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0}; // 1 -> 0 reaches tc
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 10, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0}; // press in DONE discarded
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 10, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1}; // restart clears win
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 70, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0}; // idle round times out
        tbl[10] = '{1'b0, 1'b0, 1'b0, 10, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 10, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1}; // dir_sw ignored mid-round

        n_chk = 0; n_fail = 0; ld_n = 0; cnt_n = 0; cnt_n_w = 0;
        tc_ovr_en = 1'b0; tc_ovr = 1'b0;
        clr = 1'b0; start_n = 1'b1; press_n = 1'b1; dir_sw = 1'b1;
        step(); step();
        chk("rst_ld",      32'(bus_a.ld),      32'd0);
        chk("rst_cnt",     32'(bus_a.cnt),     32'd0);
        chk("rst_up",      32'(bus_a.up),      32'd1);
        chk("rst_win",     32'(bus_a.win),     32'd0);
        chk("rst_timeout", 32'(bus_a.timeout), 32'd0);
        chk("rst_busy",    32'(bus_a.busy),    32'd0);
        chk("rst_state",   32'(dut_a.state),   32'(IDLE));
        clr = 1'b1;
        step(); step();

        foreach (tbl[i]) begin
            start_n = tbl[i].start_n; press_n = tbl[i].press_n; dir_sw = tbl[i].dir_sw;
            ld_n = 0; cnt_n = 0;
            repeat (tbl[i].ncyc) step();
            chk($sformatf("vec%0d_ld_pulses", i),  32'(ld_n),          32'(tbl[i].ld_n));
            chk($sformatf("vec%0d_cnt_pulses", i), 32'(cnt_n),         32'(tbl[i].cnt_n));
            chk($sformatf("vec%0d_up", i),         32'(bus_a.up),      32'(tbl[i].up));
            chk($sformatf("vec%0d_win", i),        32'(bus_a.win),     32'(tbl[i].win));
            chk($sformatf("vec%0d_timeout", i),    32'(bus_a.timeout), 32'(tbl[i].timeout));
            chk($sformatf("vec%0d_busy", i),       32'(bus_a.busy),    32'(tbl[i].busy));
        end

        // Reset mid-RUN with up=0 acts within the same cycle.
        chk("t1_pre_up", 32'(bus_a.up), 32'd0);
        #2 clr = 1'b0;
        #1;
        chk("t1_ld",      32'(bus_a.ld),      32'd0);
        chk("t1_cnt",     32'(bus_a.cnt),     32'd0);
        chk("t1_up",      32'(bus_a.up),      32'd1);
        chk("t1_win",     32'(bus_a.win),     32'd0);
        chk("t1_timeout", 32'(bus_a.timeout), 32'd0);
        chk("t1_busy",    32'(bus_a.busy),    32'd0);
        chk("t1_state",   32'(dut_a.state),   32'(IDLE));
        step(); step();
        clr = 1'b1;
        ld_n = 0; cnt_n = 0;
        repeat (10) step();
        chk("t1_release_ld",  32'(ld_n),  32'd0);
        chk("t1_release_cnt", 32'(cnt_n), 32'd0);

        // Start latency: ld exactly after edge DEB_CYCLES+3.
        dir_sw = 1'b0; start_n = 1'b0; ld_n = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 6) chk("t2_ld_e6", 32'(bus_a.ld), 32'd0);
            if (k == 7) chk("t2_ld_e7", 32'(bus_a.ld), 32'd1);
            if (k == 7) chk("t2_up",    32'(bus_a.up), 32'd0);
            if (k == 8) chk("t2_ld_e8", 32'(bus_a.ld), 32'd0);
        end
        chk("t2_busy",     32'(bus_a.busy), 32'd1);
        chk("t2_ld_total", 32'(ld_n),       32'd1);
        start_n = 1'b1;
        repeat (8) step();

        // Bouncy press: only the final settled fall counts.
        cnt_n = 0;
        for (int i = 0; i < 6; i++) begin
            press_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(); step();
        end
        press_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 6) chk("t3_cnt_e6", 32'(bus_a.cnt), 32'd0);
            if (k == 7) chk("t3_cnt_e7", 32'(bus_a.cnt), 32'd1);
            if (k == 8) chk("t3_cnt_e8", 32'(bus_a.cnt), 32'd0);
            if (k == 8) chk("t3_win_e8", 32'(bus_a.win), 32'd0);
            if (k == 9) chk("t3_win_e9", 32'(bus_a.win), 32'd1);
        end
        chk("t3_cnt_total", 32'(cnt_n), 32'd1);
        press_n = 1'b1;
        repeat (8) step();

        // Timeout exactly 64 cycles after entering RUN.
        dir_sw = 1'b1; start_n = 1'b0;
        wait_ld(1'b0, "t5_ld");
        start_n = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            step();
            if (k == 64) chk("t5_timeout_64", 32'(bus_a.timeout), 32'd0);
            if (k == 64) chk("t5_busy_64",    32'(bus_a.busy),    32'd1);
            if (k == 65) chk("t5_timeout_65", 32'(bus_a.timeout), 32'd1);
            if (k == 65) chk("t5_busy_65",    32'(bus_a.busy),    32'd0);
            if (k == 65) chk("t5_win_65",     32'(bus_a.win),     32'd0);
        end

        // Start and press events in the same RUN cycle.
        start_n = 1'b0;
        wait_ld(1'b0, "t6a_first_ld");
        start_n = 1'b1;
        repeat (8) step();
        ld_n = 0; cnt_n = 0;
        start_n = 1'b0; press_n = 1'b0;
        repeat (10) step();
        chk("t6a_ld",   32'(ld_n),       32'd1);
        chk("t6a_cnt",  32'(cnt_n),      32'd0);
        chk("t6a_busy", 32'(bus_a.busy), 32'd1);
        start_n = 1'b1; press_n = 1'b1;
        repeat (8) step();

        // tc rising in the timer-expiry cycle.
        start_n = 1'b0;
        wait_ld(1'b0, "t6b_ld");
        start_n = 1'b1;
        repeat (64) step();
        chk("t6b_win_pre",  32'(bus_a.win),     32'd0);
        chk("t6b_busy_pre", 32'(bus_a.busy),    32'd1);
        tc_ovr_en = 1'b1; tc_ovr = 1'b1;
        step();
        chk("t6b_win",     32'(bus_a.win),     32'd1);
        chk("t6b_timeout", 32'(bus_a.timeout), 32'd0);
        chk("t6b_busy",    32'(bus_a.busy),    32'd0);
        tc_ovr_en = 1'b0; tc_ovr = 1'b0;

        // Win on the long-round instance: 14 presses take 1 -> 15.
        dir_sw = 1'b1; start_n = 1'b0;
        wait_ld(1'b1, "t4_ld");
        start_n = 1'b1;
        repeat (8) step();
        cnt_n_w = 0;
        for (int i = 0; i < 14; i++) begin
            press_n = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                step();
                if (i == 13 && k == 8) chk("t4_win_e8", 32'(bus_w.win), 32'd0);
                if (i == 13 && k == 9) chk("t4_win_e9", 32'(bus_w.win), 32'd1);
            end
            press_n = 1'b1;
            repeat (10) step();
        end
        chk("t4_cnt_total", 32'(cnt_n_w),     32'd14);
        chk("t4_busy",      32'(bus_w.busy),  32'd0);
        chk("t4_state",     32'(dut_w.state), 32'(DONE));
        press_n = 1'b0;
        repeat (10) step();
        press_n = 1'b1;
        repeat (10) step();
        chk("t4_no_15th_cnt", 32'(cnt_n_w),   32'd14);
        chk("t4_win_held",    32'(bus_w.win), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
